// File: rtl/alarm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_multi_ctrl
// Brief    : N-channel alarm compare/ring/snooze controller. The optional macro
//            ALARM_AUTO_SNOOZE_EN turns a ring timeout into an automatic snooze.
// Revision : 1.0 - initial release
// ============================================================================

module alarm_multi_ctrl #(
    parameter int N_ALARMS      = 4,
    parameter int TIME_W        = 17,
    parameter int RING_CYCLES   = 6000000,
    parameter int SNOOZE_CYCLES = 30000000,
    parameter int MAX_SNOOZE    = 3,
    localparam int ID_W         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [N_ALARMS-1:0]          ALARM_ENABLE,
    input  logic [TIME_W-1:0]            CURRENT_TIME,
    input  logic [N_ALARMS*TIME_W-1:0]   ALARM_TIME,
    input  logic                         SNOOZE,
    input  logic                         STOP,
    output logic [N_ALARMS-1:0]          ALARM_ACTIVE,
    output logic                         ALARM_DOING,
    output logic [ID_W-1:0]              ALARM_ID,
    output logic                         SNOOZE_PENDING
);

    localparam int c_max_cyc = (RING_CYCLES > SNOOZE_CYCLES) ? RING_CYCLES : SNOOZE_CYCLES;
    localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;
    localparam int c_snz_w   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [c_cnt_w-1:0] c_ring_last = c_cnt_w'(RING_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_snz_last  = c_cnt_w'(SNOOZE_CYCLES - 1);
    localparam logic [c_snz_w-1:0] c_max_snz   = c_snz_w'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;

    logic [N_ALARMS-1:0] w_ringing;
    logic [N_ALARMS-1:0] w_snoozed;
    logic [ID_W-1:0]     w_id;

    generate
        for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
            state_t               r_state;
            logic [c_cnt_w-1:0]   r_cnt;
            logic [c_snz_w-1:0]   r_snz;
            logic                 r_hit_d;
            logic                 w_hit;
            logic                 w_trig;
            logic                 w_snz_ok;

            assign w_hit    = ALARM_ENABLE[gi] && (CURRENT_TIME == ALARM_TIME[gi*TIME_W +: TIME_W]);
            assign w_trig   = w_hit && !r_hit_d;
            assign w_snz_ok = (r_snz < c_max_snz);

            // Disable outranks every button and timer; one counter serves both timed states.
            always_ff @(posedge CLK) begin
                if (!RESETN) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_snz   <= '0;
                    r_hit_d <= 1'b0;
                end else begin
                    r_hit_d <= w_hit;
                    if (!ALARM_ENABLE[gi]) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_snz   <= '0;
                    end else begin
                        case (r_state)
                            ST_IDLE: begin
                                if (w_trig) begin
                                    r_state <= ST_RINGING;
                                    r_cnt   <= '0;
                                    r_snz   <= '0;
                                end
                            end
                            ST_RINGING: begin
                                if (STOP) begin
                                    r_state <= ST_IDLE;
                                    r_cnt   <= '0;
                                end else if (SNOOZE && w_snz_ok) begin
                                    r_state <= ST_SNOOZED;
                                    r_snz   <= r_snz + 1'b1;
                                    r_cnt   <= '0;
                                end else if (r_cnt == c_ring_last) begin
                                    r_cnt   <= '0;
`ifdef ALARM_AUTO_SNOOZE_EN
                                    if (w_snz_ok) begin
                                        r_state <= ST_SNOOZED;
                                        r_snz   <= r_snz + 1'b1;
                                    end else begin
                                        r_state <= ST_IDLE;
                                    end
`else
                                    r_state <= ST_IDLE;
`endif
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            ST_SNOOZED: begin
                                if (STOP) begin
                                    r_state <= ST_IDLE;
                                    r_cnt   <= '0;
                                end else if (r_cnt == c_snz_last) begin
                                    r_state <= ST_RINGING;
                                    r_cnt   <= '0;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            default: begin
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                                r_snz   <= '0;
                            end
                        endcase
                    end
                end
            end

            assign w_ringing[gi] = (r_state == ST_RINGING);
            assign w_snoozed[gi] = (r_state == ST_SNOOZED);
        end
    endgenerate

    // Scan downward so the lowest ringing index wins.
    always_comb begin
        w_id = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (w_ringing[i]) w_id = ID_W'(i);
        end
    end

    assign ALARM_ACTIVE   = w_ringing;
    assign ALARM_DOING    = |w_ringing;
    assign ALARM_ID       = w_id;
    assign SNOOZE_PENDING = |w_snoozed;

endmodule

`default_nettype wire

// File: tb/tb_alarm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_multi_ctrl
// Brief    : Scoreboard bench for alarm_multi_ctrl; directed scenarios then
//            random buttons/times/enables against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alarm_multi_ctrl;

    localparam int N      = 2;
    localparam int TW     = 17;
    localparam int RING   = 10;
    localparam int SNZ    = 20;
    localparam int MAXS   = 2;

    logic              CLK;
    logic              RESETN;
    logic [N-1:0]      ALARM_ENABLE;
    logic [TW-1:0]     CURRENT_TIME;
    logic [N*TW-1:0]   ALARM_TIME;
    logic              SNOOZE;
    logic              STOP;
    logic [N-1:0]      ALARM_ACTIVE;
    logic              ALARM_DOING;
    logic [0:0]        ALARM_ID;
    logic              SNOOZE_PENDING;

    alarm_multi_ctrl #(
        .N_ALARMS      (N),
        .TIME_W        (TW),
        .RING_CYCLES   (RING),
        .SNOOZE_CYCLES (SNZ),
        .MAX_SNOOZE    (MAXS)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .ALARM_ENABLE   (ALARM_ENABLE),
        .CURRENT_TIME   (CURRENT_TIME),
        .ALARM_TIME     (ALARM_TIME),
        .SNOOZE         (SNOOZE),
        .STOP           (STOP),
        .ALARM_ACTIVE   (ALARM_ACTIVE),
        .ALARM_DOING    (ALARM_DOING),
        .ALARM_ID       (ALARM_ID),
        .SNOOZE_PENDING (SNOOZE_PENDING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] act;
        logic         doing;
        logic [0:0]   id;
        logic         pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [TW-1:0] T_A = {5'd7,  6'd30, 6'd0};
    localparam logic [TW-1:0] T_B = {5'd23, 6'd59, 6'd59};
    localparam logic [TW-1:0] T_C = {5'd0,  6'd0,  6'd0};
    localparam logic [TW-1:0] T_D = {5'd12, 6'd0,  6'd1};

    function automatic logic [TW-1:0] pick(input int s);
        case (s)
            0:       return T_A;
            1:       return T_B;
            2:       return T_C;
            default: return T_D;
        endcase
    endfunction

    // Reference model: mode 0 idle, 1 ringing, 2 snoozed; 'left' counts remaining cycles.
    int mode [N];
    int left [N];
    int used [N];
    bit prev_hit [N];
`ifdef ALARM_AUTO_SNOOZE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic model_step();
        exp_t e;
        bit   hit;
        bit   trig;
        if (!RESETN) begin
            for (int i = 0; i < N; i++) begin
                mode[i] = 0; left[i] = 0; used[i] = 0; prev_hit[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                hit  = ALARM_ENABLE[i] && (CURRENT_TIME == ALARM_TIME[i*TW +: TW]);
                trig = hit && !prev_hit[i];
                prev_hit[i] = hit;
                if (!ALARM_ENABLE[i]) begin
                    mode[i] = 0; left[i] = 0; used[i] = 0;
                end else if (mode[i] == 1) begin
                    if (STOP) mode[i] = 0;
                    else if (SNOOZE && used[i] < MAXS) begin
                        mode[i] = 2; left[i] = SNZ; used[i]++;
                    end else if (left[i] == 1) begin
                        if (AUTO && used[i] < MAXS) begin
                            mode[i] = 2; left[i] = SNZ; used[i]++;
                        end else mode[i] = 0;
                    end else left[i]--;
                end else if (mode[i] == 2) begin
                    if (STOP) mode[i] = 0;
                    else if (left[i] == 1) begin
                        mode[i] = 1; left[i] = RING;
                    end else left[i]--;
                end else if (trig) begin
                    mode[i] = 1; left[i] = RING; used[i] = 0;
                end
            end
        end
        e = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mode[i] == 1) begin
                e.act[i] = 1'b1;
                e.id     = 1'(i);
            end
            if (mode[i] == 2) e.pend = 1'b1;
        end
        e.doing = |e.act;
        sb_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ALARM_ACTIVE",   8'(ALARM_ACTIVE),   8'(e.act));
                check("ALARM_DOING",    8'(ALARM_DOING),    8'(e.doing));
                check("ALARM_ID",       8'(ALARM_ID),       8'(e.id));
                check("SNOOZE_PENDING", 8'(SNOOZE_PENDING), 8'(e.pend));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_snooze();
        SNOOZE = 1'b1; cyc(1); SNOOZE = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP = 1'b1; cyc(1); STOP = 1'b0;
    endtask

    initial begin
        int idx;
        RESETN       = 1'b0;
        ALARM_ENABLE = '0;
        CURRENT_TIME = T_D;
        ALARM_TIME   = {T_B, T_A};
        SNOOZE       = 1'b0;
        STOP         = 1'b0;
        cyc(3);
        RESETN = 1'b1;
        cyc(2);

        // Long match rings once then self-stops.
        ALARM_ENABLE = 2'b01;
        CURRENT_TIME = T_A; cyc(50);
        CURRENT_TIME = T_D; cyc(3);

        // Snooze twice, third snooze ignored.
        CURRENT_TIME = T_A; cyc(1);
        CURRENT_TIME = T_D; cyc(3);
        pulse_snooze(); cyc(25);
        pulse_snooze(); cyc(22);
        pulse_snooze(); cyc(15);

        // STOP and SNOOZE together.
        CURRENT_TIME = T_A; cyc(1);
        CURRENT_TIME = T_D; cyc(2);
        SNOOZE = 1'b1; STOP = 1'b1; cyc(1);
        SNOOZE = 1'b0; STOP = 1'b0; cyc(3);

        // Both channels on the same time, then STOP clears both.
        ALARM_ENABLE = 2'b11;
        ALARM_TIME   = {T_A, T_A};
        CURRENT_TIME = T_A; cyc(1);
        CURRENT_TIME = T_D; cyc(4);
        pulse_stop(); cyc(3);

        // Drop ENABLE0 mid-ring while raising ENABLE1 during the match.
        ALARM_ENABLE = 2'b01;
        CURRENT_TIME = T_A; cyc(4);
        ALARM_ENABLE = 2'b10; cyc(14);
        CURRENT_TIME = T_D; ALARM_ENABLE = 2'b11; cyc(3);

        // Reset mid-snooze with a persistent match.
        CURRENT_TIME = T_A; cyc(3);
        pulse_snooze(); cyc(5);
        RESETN = 1'b0; cyc(1);
        RESETN = 1'b1; cyc(15);
        CURRENT_TIME = T_D; cyc(80);

        // Random phase.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) CURRENT_TIME = pick(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 31) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                ALARM_ENABLE[idx] = ~ALARM_ENABLE[idx];
            end
            if ($urandom_range(0, 127) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                ALARM_TIME[idx*TW +: TW] = pick(int'($urandom_range(0, 1)));
            end
            SNOOZE = ($urandom_range(0, 24) == 0);
            STOP   = ($urandom_range(0, 79) == 0);
            RESETN = ($urandom_range(0, 599) != 0);
            cyc(1);
        end
        SNOOZE = 1'b0; STOP = 1'b0; RESETN = 1'b1;
        cyc(3);
        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
